// File: rtl/fetch_issue_ctrl.sv
// rtl/fetch_issue_ctrl.sv - decode latch, issue handshake and fetch PC steering (redirect/replay/halt)
// Define HAZARD_SCOREBOARD_EN to build the register scoreboard that holds issue on hazards.
module fetch_issue_ctrl #(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = 32'h40,
  parameter int               NREGS    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] pc_in,
  input  logic [DBITS-1:0] inst_in,
  input  logic             redirect_valid,
  input  logic [DBITS-1:0] redirect_pc,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [3:0]       wb_reg,
  output logic             sel_pc,
  output logic [DBITS-1:0] next_pc,
  output logic             pc_stay,
  output logic             id_valid,
  output logic [DBITS-1:0] id_pc,
  output logic [DBITS-1:0] id_inst,
  output logic             halted
);

  typedef enum logic [1:0] {RUN, DROP, HALT} state_t;
  localparam logic [DBITS-1:0] HALT_WORD = DBITS'(32'h0000_dead);

  state_t           state_q, state_d;
  logic             f_valid_q;
  logic [DBITS-1:0] f_pc_q;
  logic             id_full_q, id_full_d;
  logic [DBITS-1:0] id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic             hazard, fire, accept;

`ifdef HAZARD_SCOREBOARD_EN
  logic [NREGS-1:0] pending_q, pending_d;
  logic [3:0]       rd, rs1, rs2;
  logic             wr;

  assign rd     = id_inst_q[31:28];
  assign rs1    = id_inst_q[27:24];
  assign rs2    = id_inst_q[23:20];
  assign wr     = id_inst_q[19];
  assign hazard = pending_q[rs1] | pending_q[rs2] | (wr & pending_q[rd]);

  // Clear applied first so a same-cycle set of the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)
      pending_d[wb_reg] = 1'b0;
    if (fire && wr)
      pending_d[rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end
`else
  localparam int UNUSED_NREGS = NREGS;
  logic          unused_wb;
  assign unused_wb = ^{wb_valid, wb_reg};
  assign hazard    = 1'b0;
`endif

  assign id_valid = id_full_q & ~hazard & ~redirect_valid;
  assign fire     = id_valid & ex_ready;
  assign accept   = ~id_full_q | fire;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign halted   = (state_q == HALT);

  always_comb begin
    state_d   = state_q;
    id_full_d = id_full_q & ~fire;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    sel_pc    = 1'b0;
    next_pc   = '0;
    pc_stay   = 1'b0;
    if (redirect_valid) begin
      sel_pc    = 1'b1;
      next_pc   = redirect_pc;
      id_full_d = 1'b0;
      state_d   = DROP;
    end else begin
      case (state_q)
        RUN: begin
          if (f_valid_q) begin
            // A word that cannot be taken is refetched; the next word in flight is stale.
            if (!accept) begin
              sel_pc  = 1'b1;
              next_pc = f_pc_q;
              state_d = DROP;
            end else if (inst_in == HALT_WORD) begin
              state_d = HALT;
            end else begin
              id_full_d = 1'b1;
              id_pc_d   = f_pc_q;
              id_inst_d = inst_in;
            end
          end
        end
        DROP:    state_d = RUN;
        HALT:    pc_stay = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      f_valid_q <= 1'b0;
      f_pc_q    <= START_PC;
      id_full_q <= 1'b0;
      id_pc_q   <= '0;
      id_inst_q <= '0;
    end else begin
      state_q   <= state_d;
      f_valid_q <= 1'b1;
      f_pc_q    <= pc_in;
      id_full_q <= id_full_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// tb/tb_fetch_issue_ctrl.sv - directed and randomized scoreboard bench for fetch_issue_ctrl
module tb_fetch_issue_ctrl;
  localparam logic [31:0] START_PC  = 32'h40;
  localparam logic [31:0] HALT_WORD = 32'h0000_dead;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, inst_in, redirect_pc, next_pc, id_pc, id_inst;
  logic        redirect_valid, ex_ready, wb_valid, sel_pc, pc_stay, id_valid, halted;
  logic [3:0]  wb_reg;

  int          checks = 0;
  int          errors = 0;
  int          fires  = 0;
  logic [31:0] mem [256];
  logic [63:0] exp_q [$];
  logic [15:0] pend;
  logic [31:0] fpc, prev_fpc;
  logic        smp_sel, smp_stay;
  logic [31:0] smp_next;

  fetch_issue_ctrl #(.DBITS(32), .START_PC(32'h40), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .sel_pc(sel_pc), .next_pc(next_pc),
    .pc_stay(pc_stay), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Program order from a start address up to (not including) the halt word.
  task automatic refill(input logic [31:0] start);
    logic [31:0] pc;
    pc = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      if (mem[pc[9:2]] == HALT_WORD) break;
      exp_q.push_back({pc, mem[pc[9:2]]});
      pc = pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    smp_sel  = sel_pc;
    smp_next = next_pc;
    smp_stay = pc_stay;
  end

  always @(negedge clk) begin : monitor
    logic [63:0] e;
    logic        fire_m;
    if (reset) begin
      chk1("rst_sel_pc", sel_pc, 1'b0);
      chk32("rst_next_pc", next_pc, 32'h0);
      chk1("rst_pc_stay", pc_stay, 1'b0);
      chk1("rst_id_valid", id_valid, 1'b0);
      chk32("rst_id_pc", id_pc, 32'h0);
      chk32("rst_id_inst", id_inst, 32'h0);
      chk1("rst_halted", halted, 1'b0);
      refill(START_PC);
      pend = '0;
    end else begin
      fire_m = id_valid & ex_ready;
      if (redirect_valid) begin
        chk1("redir_id_valid", id_valid, 1'b0);
        chk1("redir_sel_pc", sel_pc, 1'b1);
        chk32("redir_next_pc", next_pc, redirect_pc);
        refill(redirect_pc);
      end else if (sel_pc) begin
        chk32("replay_next_pc", next_pc, prev_fpc);
      end else begin
        chk32("idle_next_pc", next_pc, 32'h0);
      end
      if (fire_m) begin
        fires++;
        chk1("issue_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk32("issue_pc", id_pc, e[63:32]);
          chk32("issue_inst", id_inst, e[31:0]);
        end
      end
`ifdef HAZARD_SCOREBOARD_EN
      if (id_valid)
        chk1("issue_hazard_free",
             pend[id_inst[27:24]] | pend[id_inst[23:20]] | (id_inst[19] & pend[id_inst[31:28]]), 1'b0);
`endif
      if (wb_valid) pend[wb_reg] = 1'b0;
      if (fire_m && id_inst[19]) pend[id_inst[31:28]] = 1'b1;
    end
  end

  // Advance one clock: fetch model follows the sampled steering, then new inputs are applied.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic er,
                      input logic wv, input logic [3:0] wr);
    @(posedge clk);
    #1;
    prev_fpc = fpc;
    inst_in  = mem[fpc[9:2]];
    fpc      = smp_sel ? smp_next : (smp_stay ? fpc : fpc + 32'd4);
    pc_in    = fpc;
    redirect_valid = rv;
    redirect_pc    = rpc;
    ex_ready       = er;
    wb_valid       = wv;
    wb_reg         = wr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; ex_ready = 1'b0;
    wb_valid = 1'b0; wb_reg = 4'h0;
    fpc = START_PC; prev_fpc = START_PC; pc_in = START_PC; inst_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic init_plain();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);
  endtask

  task automatic hazard_test(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [3:0] r, input logic early_wb);
    init_plain();
    mem[16] = w0;
    mem[17] = w1;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      step(1'b0, 32'h0, 1'b1, (c == 4) || (early_wb && c == 2), r);
      @(negedge clk);
      if (c == 2) chk32({tag, "_writer_pc"}, id_pc, 32'h40);
`ifdef HAZARD_SCOREBOARD_EN
      if (c == 3 || c == 4) chk1({tag, "_stalled"}, id_valid, 1'b0);
      if (c == 5) begin
        chk1({tag, "_released"}, id_valid, 1'b1);
        chk32({tag, "_reader_pc"}, id_pc, 32'h44);
      end
`else
      if (c == 3) begin
        chk1({tag, "_no_stall"}, id_valid, 1'b1);
        chk32({tag, "_reader_pc"}, id_pc, 32'h44);
      end
`endif
    end
  endtask

  initial begin : stimulus
    int          fires_before;
    logic [3:0]  r, pick;
    logic [31:0] w;
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; ex_ready = 1'b0;
    wb_valid = 1'b0; wb_reg = 4'h0;
    fpc = START_PC; prev_fpc = START_PC; pc_in = START_PC; inst_in = 32'h0;

    // Startup latency, back-to-back issue, replay under sustained stall.
    init_plain();
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      step(1'b0, 32'h0, (c >= 4 && c <= 6) ? 1'b0 : 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      case (c)
        1: chk1("startup_idle", id_valid, 1'b0);
        2: begin chk1("startup_valid", id_valid, 1'b1); chk32("startup_pc0", id_pc, 32'h40); end
        3: begin chk1("second_valid", id_valid, 1'b1); chk32("startup_pc1", id_pc, 32'h44); end
        4: begin chk1("replay_sel", sel_pc, 1'b1); chk32("replay_pc", next_pc, 32'h4c); end
        5: chk1("replay_drop_sel", sel_pc, 1'b0);
        6: begin chk1("replay_again_sel", sel_pc, 1'b1); chk32("replay_again_pc", next_pc, 32'h4c); end
        7: begin chk1("drain_valid", id_valid, 1'b1); chk32("drain_pc", id_pc, 32'h48); end
        8: chk1("dropped_slot", id_valid, 1'b0);
        9: begin chk1("reload_valid", id_valid, 1'b1); chk32("reload_pc", id_pc, 32'h4c); end
        default: ;
      endcase
    end

    hazard_test("raw_r3", 32'h3008_0000, 32'h0300_0000, 4'd3, 1'b0);
    hazard_test("setwins_r5", 32'h5008_0000, 32'h0050_0000, 4'd5, 1'b1);

    // Redirect with the latch full.
    init_plain();
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step(c == 3, (c == 3) ? 32'h100 : 32'h0, c != 2, 1'b0, 4'h0);
      @(negedge clk);
      case (c)
        2: chk32("redir_pre_pc", id_pc, 32'h40);
        3: begin
          chk1("redir_kill", id_valid, 1'b0);
          chk1("redir_sel", sel_pc, 1'b1);
          chk32("redir_target", next_pc, 32'h100);
        end
        4, 5: chk1("redir_bubble", id_valid, 1'b0);
        6: begin chk1("redir_issue", id_valid, 1'b1); chk32("redir_issue_pc", id_pc, 32'h100); end
        default: ;
      endcase
    end

    // Halt word, then restart by redirect.
    init_plain();
    mem[17] = HALT_WORD;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      step(c == 5, (c == 5) ? 32'h200 : 32'h0, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      case (c)
        3, 4: begin
          chk1("halt_flag", halted, 1'b1);
          chk1("halt_stay", pc_stay, 1'b1);
          chk1("halt_no_issue", id_valid, 1'b0);
        end
        6: chk1("halt_exit", halted, 1'b0);
        8: begin chk1("halt_resume", id_valid, 1'b1); chk32("halt_resume_pc", id_pc, 32'h200); end
        default: ;
      endcase
    end

    // Randomized traffic against the program-order scoreboard.
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT_WORD) w = w ^ 32'h1;
      if ((i % 32) == 31 || $urandom_range(0, 24) == 0) w = HALT_WORD;
      mem[i] = w;
    end
    do_reset();
    fires_before = fires;
    for (int c = 0; c < 3000; c++) begin
      r = 4'($urandom_range(0, 15));
      pick = r;
      for (int k = 0; k < 16; k++) if (pend[r + 4'(k)]) pick = r + 4'(k);
      step($urandom_range(0, 31) == 0, 32'($urandom_range(0, 255)) << 2,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, pick);
    end
    @(negedge clk);
    chk1("random_progress", (fires - fires_before) > 100, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    #1 reset = 1'b1;
    #1;
    chk1("async_rst_id_valid", id_valid, 1'b0);
    chk1("async_rst_halted", halted, 1'b0);
    chk32("async_rst_id_pc", id_pc, 32'h0);
    chk32("async_rst_id_inst", id_inst, 32'h0);
    do_reset();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
